// File: rtl/msg_event_pkg.sv
// Shared types for the diagnostic event transmitter: severity encoding and record layout.
package msg_event_pkg;

    typedef enum logic [1:0] {
        SEV_INFO  = 2'd0,
        SEV_WARN  = 2'd1,
        SEV_ERROR = 2'd2,
        SEV_FATAL = 2'd3
    } sev_e;

    localparam int MSG_NUM_SRC = 4;
    localparam int MSG_TS_W    = 32;
    localparam int MSG_SRC_W   = $clog2(MSG_NUM_SRC + 1);

    localparam logic [15:0] TIMEOUT_CODE = 16'hFFFF;

    // Record layout for the default configuration; the top re-declares it with its own widths.
    typedef struct packed {
        sev_e                 sev;
        logic [MSG_SRC_W-1:0] src;
        logic [15:0]          code;
        logic [MSG_TS_W-1:0]  ts;
    } msg_rec_t;

endpackage

// File: rtl/msg_event_fifo.sv
// Synchronous record FIFO with full/empty flags; the head entry is read straight from the storage registers.
module msg_event_fifo
    import msg_event_pkg::*;
#(
    parameter type T     = msg_rec_t,
    parameter int  DEPTH = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_push,
    input  T     i_data,
    input  logic i_pop,
    output T     o_data,
    output logic o_full,
    output logic o_empty
);

    localparam int AW = $clog2(DEPTH);

    T               r_mem [DEPTH];
    logic [AW-1:0]  r_wr_ptr;
    logic [AW-1:0]  r_rd_ptr;
    logic [AW:0]    r_count;
    logic           w_wr_en;
    logic           w_rd_en;

    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);

    // A pop in the same cycle does not make room for a push into a full FIFO.
    assign w_wr_en = i_push && !o_full;
    assign w_rd_en = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_en) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wr_en, w_rd_en})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_data = r_mem[r_rd_ptr];

endmodule

// File: rtl/msg_event_tx.sv
// Severity-tagged event transmitter: round-robin source arbitration, timestamping, filtering and counters.
// Optional watchdog FATAL injection is enabled by defining MSG_TIMEOUT_EN.
module msg_event_tx
    import msg_event_pkg::*;
#(
    parameter int  NUM_SRC = 4,
    parameter int  DEPTH   = 8,
    parameter int  CNT_W   = 16,
    parameter int  TS_W    = 32,
    localparam int SRC_W   = $clog2(NUM_SRC + 1),
    localparam int REC_W   = 2 + SRC_W + 16 + TS_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_SRC-1:0]    ev_valid,
    output logic [NUM_SRC-1:0]    ev_ready,
    input  logic [2*NUM_SRC-1:0]  ev_sev,
    input  logic [16*NUM_SRC-1:0] ev_code,
    input  logic                  info_en,
    input  logic                  warn_en,
    input  logic [CNT_W-1:0]      error_limit,
`ifdef MSG_TIMEOUT_EN
    input  logic [TS_W-1:0]       timeout_cfg,
`endif
    output logic                  msg_valid,
    input  logic                  msg_ready,
    output logic [REC_W-1:0]      msg_data,
    output logic [CNT_W-1:0]      error_count,
    output logic [CNT_W-1:0]      warn_count,
    output logic [CNT_W-1:0]      drop_count,
    output logic                  fatal_flag,
    output logic                  stop_req
);

    localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    typedef struct packed {
        sev_e             sev;
        logic [SRC_W-1:0] src;
        logic [15:0]      code;
        logic [TS_W-1:0]  ts;
    } rec_t;

    logic [PTR_W-1:0]   r_rr_ptr;
    logic [TS_W-1:0]    r_ts;
    logic [CNT_W-1:0]   r_error_count;
    logic [CNT_W-1:0]   r_warn_count;
    logic [CNT_W-1:0]   r_drop_count;
    logic               r_fatal_flag;
    logic               r_stop_req;

    logic [PTR_W-1:0]   w_scan_idx;
    logic [PTR_W-1:0]   w_grant_idx;
    logic [NUM_SRC-1:0] w_grant_oh;
    logic               w_src_grant;
    logic               w_inject;
    logic               w_take;
    sev_e               w_sev;
    logic [SRC_W-1:0]   w_src;
    logic [15:0]        w_code;
    logic               w_queue;
    logic               w_count_err;
    logic               w_count_warn;
    logic               w_fatal_new;
    logic               w_drop;
    logic [CNT_W-1:0]   w_err_next;
    logic               w_full;
    logic               w_empty;
    rec_t               w_wr_rec;
    rec_t               w_rd_rec;

    // First requesting source at or after the pointer; a watchdog injection pre-empts all sources.
    always_comb begin
        w_grant_oh  = '0;
        w_grant_idx = '0;
        w_scan_idx  = '0;
        w_src_grant = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            w_scan_idx = PTR_W'((int'(r_rr_ptr) + k) % NUM_SRC);
            if (!w_src_grant && ev_valid[w_scan_idx]) begin
                w_src_grant = 1'b1;
                w_grant_idx = w_scan_idx;
            end
        end
        if (w_inject) begin
            w_src_grant = 1'b0;
        end
        if (w_src_grant) begin
            w_grant_oh[w_grant_idx] = 1'b1;
        end
    end

    assign ev_ready = w_grant_oh;
    assign w_take   = w_src_grant || w_inject;

    always_comb begin
        w_sev  = SEV_INFO;
        w_src  = '0;
        w_code = '0;
        if (w_inject) begin
            w_sev  = SEV_FATAL;
            w_src  = SRC_W'(NUM_SRC);
            w_code = TIMEOUT_CODE;
        end else begin
            for (int k = 0; k < NUM_SRC; k++) begin
                if (w_grant_oh[k]) begin
                    w_sev  = sev_e'(ev_sev[2*k +: 2]);
                    w_src  = SRC_W'(k);
                    w_code = ev_code[16*k +: 16];
                end
            end
        end
    end

    // Only the first FATAL is counted and queued; later ones are silently consumed.
    always_comb begin
        w_queue = 1'b0;
        if (w_take) begin
            case (w_sev)
                SEV_INFO:  w_queue = info_en;
                SEV_WARN:  w_queue = warn_en;
                SEV_ERROR: w_queue = 1'b1;
                SEV_FATAL: w_queue = !r_fatal_flag;
                default:   w_queue = 1'b0;
            endcase
        end
    end

    assign w_fatal_new  = w_take && (w_sev == SEV_FATAL) && !r_fatal_flag;
    assign w_count_err  = (w_take && (w_sev == SEV_ERROR)) || w_fatal_new;
    assign w_count_warn = w_take && (w_sev == SEV_WARN);
    assign w_drop       = w_queue && w_full;
    assign w_err_next   = (r_error_count == '1) ? r_error_count : r_error_count + 1'b1;

`ifdef MSG_TIMEOUT_EN
    logic [TS_W-1:0] r_wd_cnt;
    logic            r_wd_done;

    // Watchdog fires once, on the cycle its count since reset equals the programmed timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wd_cnt  <= '0;
            r_wd_done <= 1'b0;
        end else if (!r_wd_done) begin
            r_wd_cnt <= r_wd_cnt + 1'b1;
            if ((timeout_cfg != '0) && (r_wd_cnt == timeout_cfg)) begin
                r_wd_done <= 1'b1;
            end
        end
    end

    assign w_inject = !r_wd_done && (timeout_cfg != '0) && (r_wd_cnt == timeout_cfg) && !r_fatal_flag;
`else
    assign w_inject = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr      <= '0;
            r_ts          <= '0;
            r_error_count <= '0;
            r_warn_count  <= '0;
            r_drop_count  <= '0;
            r_fatal_flag  <= 1'b0;
            r_stop_req    <= 1'b0;
        end else begin
            r_ts <= r_ts + 1'b1;
            if (w_src_grant) begin
                r_rr_ptr <= PTR_W'((int'(w_grant_idx) + 1) % NUM_SRC);
            end
            if (w_count_err) begin
                r_error_count <= w_err_next;
                if ((w_sev == SEV_FATAL) ||
                    ((error_limit != '0) && (w_err_next == error_limit))) begin
                    r_stop_req <= 1'b1;
                end
            end
            if (w_fatal_new) begin
                r_fatal_flag <= 1'b1;
            end
            if (w_count_warn && (r_warn_count != '1)) begin
                r_warn_count <= r_warn_count + 1'b1;
            end
            if (w_drop && (r_drop_count != '1)) begin
                r_drop_count <= r_drop_count + 1'b1;
            end
        end
    end

    assign w_wr_rec = '{sev: w_sev, src: w_src, code: w_code, ts: r_ts};

    msg_event_fifo #(
        .T     (rec_t),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_queue),
        .i_data  (w_wr_rec),
        .i_pop   (msg_ready),
        .o_data  (w_rd_rec),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign msg_valid   = !w_empty;
    assign msg_data    = w_rd_rec;
    assign error_count = r_error_count;
    assign warn_count  = r_warn_count;
    assign drop_count  = r_drop_count;
    assign fatal_flag  = r_fatal_flag;
    assign stop_req    = r_stop_req;

endmodule
